exe_alu_cc: RTL and testbench

- Execute-stage ALU plus condition-code register for the Y86-64 core.
- Computes valE for OPq/address arithmetic and registers the result.
- Updates the ZF/SF/OF condition codes on request and drives cur_cc straight into the downstream branch/cmov condition evaluator.
- Owns the only architectural CC state in the design. Supports stall, flush and exception-driven CC suppression.

---
 rtl/exe_alu_cc.sv | 87 ++++++++
 tb/tb_exe_alu_cc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_cc.sv
// Execute-stage ALU with the architectural {ZF,SF,OF} register; valE/out_valid/fun_err one cycle after acceptance, new CCs visible the cycle after the op.
// No backpressure output: stall freezes every register, flush bubbles the result path but never touches the CCs.
module exe_alu_cc #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic             set_cc,
  input  logic             cc_block,
  output logic             out_valid,
  output logic [WIDTH-1:0] valE,
  output logic [2:0]       cur_cc,
  output logic             fun_err
);

  logic [WIDTH-1:0] w_t;
  logic             w_illegal;
  logic             w_of;
  logic             w_msb_a;
  logic             w_msb_b;
  logic [2:0]       w_flags;
  logic             w_cc_we;

  logic             r_valid;
  logic [WIDTH-1:0] r_vale;
  logic [2:0]       r_cc;
  logic             r_fun_err;

  assign w_msb_a = alu_a[WIDTH-1];
  assign w_msb_b = alu_b[WIDTH-1];

  // Y86 operand order: the result is always B op A.
  always_comb begin
    w_t       = '0;
    w_illegal = 1'b0;
    w_of      = 1'b0;
    case (alu_fun)
      4'd0: begin
        w_t  = alu_b + alu_a;
        w_of = (w_msb_a == w_msb_b) & (w_t[WIDTH-1] != w_msb_a);
      end
      4'd1: begin
        w_t  = alu_b - alu_a;
        w_of = (w_msb_a != w_msb_b) & (w_t[WIDTH-1] != w_msb_b);
      end
      4'd2:    w_t = alu_b & alu_a;
      4'd3:    w_t = alu_b ^ alu_a;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_flags = {(w_t == '0), w_t[WIDTH-1], w_of};
  assign w_cc_we = in_valid & set_cc & ~cc_block & ~w_illegal & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_vale    <= '0;
      r_fun_err <= 1'b0;
      r_cc      <= CC_RESET;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_vale    <= '0;
      r_fun_err <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_vale    <= w_t;
        r_fun_err <= w_illegal;
      end
      if (w_cc_we) r_cc <= w_flags;
    end
  end

  assign out_valid = r_valid;
  assign valE      = r_vale;
  assign cur_cc    = r_cc;
  assign fun_err   = r_fun_err;

endmodule

// File: tb/tb_exe_alu_cc.sv
// Bench for exe_alu_cc: arithmetic reference model plus directed literal expectations and random traffic.
module tb_exe_alu_cc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  alu_fun;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic        set_cc;
  logic        cc_block;
  logic        out_valid;
  logic [63:0] valE;
  logic [2:0]  cur_cc;
  logic        fun_err;

  int tests;
  int fails;

  // reference state
  logic        m_valid;
  logic [63:0] m_vale;
  logic [2:0]  m_cc;
  logic        m_err;

  exe_alu_cc #(.WIDTH(64), .CC_RESET(3'b100)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b), .set_cc(set_cc),
    .cc_block(cc_block), .out_valid(out_valid), .valE(valE), .cur_cc(cur_cc),
    .fun_err(fun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Result and flags from plain integer arithmetic: overflow means the exact
  // signed result does not survive truncation to 64 bits.
  task automatic ref_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] t, output logic ill, output logic [2:0] fl);
    longint sa, sb, st;
    logic signed [65:0] exact;
    logic of;
    sa = a; sb = b; of = 1'b0; ill = 1'b0; t = 64'd0;
    exact = '0;
    case (f)
      4'd0: begin t = b + a; exact = 66'(sb) + 66'(sa); end
      4'd1: begin t = b - a; exact = 66'(sb) - 66'(sa); end
      4'd2: t = b & a;
      4'd3: t = b ^ a;
      default: ill = 1'b1;
    endcase
    st = t;
    if (f == 4'd0 || f == 4'd1) of = (exact != 66'(st));
    fl = {(t == 64'd0), (st < 0), of};
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    chk({tag, ".valE"}, valE, m_vale);
    chk({tag, ".cur_cc"}, {61'd0, cur_cc}, {61'd0, m_cc});
    chk({tag, ".fun_err"}, {63'd0, fun_err}, {63'd0, m_err});
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, compare.
  task automatic step(input logic v, input logic [3:0] f, input logic [63:0] a,
                      input logic [63:0] b, input logic sc, input logic blk,
                      input logic stl, input logic fl, input string tag);
    logic [63:0] t;
    logic ill;
    logic [2:0] flags;
    in_valid = v; alu_fun = f; alu_a = a; alu_b = b;
    set_cc = sc; cc_block = blk; stall = stl; flush = fl;
    ref_op(f, a, b, t, ill, flags);
    @(posedge clk);
    #1;
    if (fl) begin
      m_valid = 1'b0; m_vale = 64'd0; m_err = 1'b0;
    end else if (!stl) begin
      m_valid = v;
      if (v) begin m_vale = t; m_err = ill; end
      if (v && sc && !blk && !ill) m_cc = flags;
    end
    check_model(tag);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_vale = 64'd0; m_cc = 3'b100; m_err = 1'b0;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'd0;
      4: return 64'd1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; in_valid = 0; stall = 0; flush = 0; alu_fun = 0;
    alu_a = 0; alu_b = 0; set_cc = 0; cc_block = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.cur_cc", {61'd0, cur_cc}, 64'd4);
    chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset.valE", valE, 64'd0);
    chk("reset.fun_err", {63'd0, fun_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    step(1, 4'd0, 64'd5, 64'd7, 1, 0, 0, 0, "add5_7");
    chk("add5_7.lit_valE", valE, 64'd12);
    chk("add5_7.lit_cc", {61'd0, cur_cc}, 64'd0);
    chk("add5_7.lit_valid", {63'd0, out_valid}, 64'd1);

    step(1, 4'd1, 64'd9, 64'd9, 1, 0, 0, 0, "sub_eq");
    chk("sub_eq.lit_cc", {61'd0, cur_cc}, 64'd4);

    step(1, 4'd0, 64'd1, MAXP, 1, 0, 0, 0, "add_ovf");
    chk("add_ovf.lit_valE", valE, MINN);
    chk("add_ovf.lit_cc", {61'd0, cur_cc}, 64'd3);

    step(1, 4'd3, 64'hDEAD, 64'hDEAD, 0, 0, 0, 0, "xor_noset");
    chk("xor_noset.lit_cc", {61'd0, cur_cc}, 64'd3);
    step(1, 4'd3, 64'hDEAD, 64'hDEAD, 1, 1, 0, 0, "xor_block");
    chk("xor_block.lit_valid", {63'd0, out_valid}, 64'd1);
    chk("xor_block.lit_cc", {61'd0, cur_cc}, 64'd3);

    for (int i = 0; i < 3; i++) begin
      step(1, 4'd1, 64'd1, 64'd0, 1, 0, 1, 0, "stall_sub");
      chk("stall_sub.lit_valE", valE, 64'd0);
      chk("stall_sub.lit_cc", {61'd0, cur_cc}, 64'd3);
    end
    step(1, 4'd1, 64'd1, 64'd0, 1, 0, 0, 0, "stall_release");
    chk("stall_release.lit_valE", valE, ONES);
    chk("stall_release.lit_cc", {61'd0, cur_cc}, 64'd2);

    step(1, 4'd0, 64'd3, 64'd4, 1, 0, 1, 1, "flush_stall");
    chk("flush_stall.lit_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_stall.lit_cc", {61'd0, cur_cc}, 64'd2);

    step(1, 4'd4, 64'd3, 64'd4, 1, 0, 0, 0, "illegal");
    chk("illegal.lit_err", {63'd0, fun_err}, 64'd1);
    chk("illegal.lit_cc", {61'd0, cur_cc}, 64'd2);

    step(1, 4'd0, 64'd1, ONES, 1, 0, 0, 0, "wrap0");
    chk("wrap0.lit_cc", {61'd0, cur_cc}, 64'd4);
    step(1, 4'd1, 64'd1, MINN, 1, 0, 0, 0, "sub_ovf");
    chk("sub_ovf.lit_cc", {61'd0, cur_cc}, 64'd1);
    step(0, 4'd0, 64'd1, MAXP, 1, 0, 0, 0, "noval_set");
    chk("noval_set.lit_cc", {61'd0, cur_cc}, 64'd1);

    step(1, 4'd0, 64'd1, MAXP, 1, 0, 0, 0, "pre_arst");
    chk("pre_arst.lit_cc", {61'd0, cur_cc}, 64'd3);
    // async reset mid-cycle while stalled, observed before the next edge
    stall = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.lit_cc", {61'd0, cur_cc}, 64'd4);
    chk("arst.lit_valid", {63'd0, out_valid}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 4'd0, 64'd5, 64'd7, 1, 0, 0, 0, "post_arst");
    chk("post_arst.lit_valE", valE, 64'd12);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 4)), pick_operand(), pick_operand(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
